// File: rtl/char_match_scheduler_pkg.sv
// rtl/char_match_scheduler_pkg.sv - shared constants, error codes and FSM encoding for the character match scheduler
package char_match_pkg;

  localparam int NUM_CHARS  = 8;
  localparam int FEAT_W     = 40;
  localparam int LN_RES_W   = 8;
  localparam int CITY_RES_W = 16;
  localparam int SLOT_W     = $clog2(NUM_CHARS);

  localparam logic [CITY_RES_W-1:0] CITY_ERR = 16'hFFFF;
  localparam logic [LN_RES_W-1:0]   LN_ERR   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    PUBLISH
  } state_t;

endpackage

// File: rtl/char_match_scheduler_if.sv
// rtl/char_match_scheduler_if.sv - request/response link between the scheduler and the shared matcher pair
interface char_match_scheduler_if;
  import char_match_pkg::*;

  logic [FEAT_W-1:0]     m_char;
  logic                  m_sel;
  logic                  m_valid;
  logic [CITY_RES_W-1:0] m_result;
  logic                  m_result_valid;

  modport master (
    output m_char, m_sel, m_valid,
    input  m_result, m_result_valid
  );

  modport slave (
    input  m_char, m_sel, m_valid,
    output m_result, m_result_valid
  );

endinterface

// File: rtl/char_match_scheduler.sv
// rtl/char_match_scheduler.sv - time-multiplexes eight plate characters through one matcher pair and publishes results atomically
module char_match_scheduler
  import char_match_pkg::*;
#(
  parameter logic [1:0] TRIG_FRAME = 2'd0,
  parameter int         TIMEOUT    = 255
) (
  input  logic                  pixelclk,
  input  logic                  reset,
  input  logic                  i_vs,
  input  logic [1:0]            frame_cnt,
  input  logic [FEAT_W-1:0]     char1,
  input  logic [FEAT_W-1:0]     char2,
  input  logic [FEAT_W-1:0]     char3,
  input  logic [FEAT_W-1:0]     char4,
  input  logic [FEAT_W-1:0]     char5,
  input  logic [FEAT_W-1:0]     char6,
  input  logic [FEAT_W-1:0]     char7,
  input  logic [FEAT_W-1:0]     char8,
  char_match_scheduler_if.master m,
  output logic [CITY_RES_W-1:0] char_result1,
  output logic [LN_RES_W-1:0]   char_result2,
  output logic [LN_RES_W-1:0]   char_result3,
  output logic [LN_RES_W-1:0]   char_result4,
  output logic [LN_RES_W-1:0]   char_result5,
  output logic [LN_RES_W-1:0]   char_result6,
  output logic [LN_RES_W-1:0]   char_result7,
  output logic [LN_RES_W-1:0]   char_result8,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err
);

  localparam int TCNT_W = $clog2(TIMEOUT);

  state_t                state, state_nxt;
  logic                  vs_d;
  logic                  trigger;
  logic [FEAT_W-1:0]     feat [NUM_CHARS];
  logic [SLOT_W-1:0]     slot;
  logic [SLOT_W-1:0]     ln_idx;
  logic [TCNT_W-1:0]     tcnt;
  logic                  timed_out;
  logic                  slot_empty;
  logic [CITY_RES_W-1:0] shadow_city;
  logic [LN_RES_W-1:0]   shadow_ln [NUM_CHARS-1];

  assign trigger    = i_vs && !vs_d && (frame_cnt == TRIG_FRAME);
  assign slot_empty = (feat[slot] == '0);
  assign ln_idx     = slot - SLOT_W'(1);
  // tcnt holds the number of WAIT cycles already spent, so this fires on the TIMEOUT-th one
  assign timed_out  = (tcnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge pixelclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trigger) state_nxt = ISSUE;
      ISSUE:   state_nxt = slot_empty ? NEXT : WAIT;
      WAIT:    if (m.m_result_valid || timed_out) state_nxt = NEXT;
      NEXT:    state_nxt = (slot == SLOT_W'(NUM_CHARS - 1)) ? PUBLISH : ISSUE;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vs_d         <= 1'b0;
      slot         <= '0;
      tcnt         <= '0;
      shadow_city  <= '0;
      m.m_char     <= '0;
      m.m_sel      <= 1'b0;
      m.m_valid    <= 1'b0;
      char_result1 <= '0;
      char_result2 <= '0;
      char_result3 <= '0;
      char_result4 <= '0;
      char_result5 <= '0;
      char_result6 <= '0;
      char_result7 <= '0;
      char_result8 <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) feat[i] <= '0;
      for (int i = 0; i < NUM_CHARS - 1; i++) shadow_ln[i] <= '0;
    end else begin
      vs_d         <= i_vs;
      m.m_valid    <= 1'b0;
      result_valid <= 1'b0;
      // busy is still high during PUBLISH, so a trigger there is an overrun too
      overrun      <= trigger && busy;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            feat[0]     <= char1;
            feat[1]     <= char2;
            feat[2]     <= char3;
            feat[3]     <= char4;
            feat[4]     <= char5;
            feat[5]     <= char6;
            feat[6]     <= char7;
            feat[7]     <= char8;
            slot        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (slot_empty) begin
            if (slot == '0) shadow_city <= '0;
            else            shadow_ln[ln_idx] <= '0;
          end else begin
            m.m_char  <= feat[slot];
            m.m_sel   <= (slot != '0);
            m.m_valid <= 1'b1;
            tcnt      <= '0;
          end
        end
        WAIT: begin
          if (m.m_result_valid) begin
            if (slot == '0) shadow_city <= m.m_result;
            else            shadow_ln[ln_idx] <= m.m_result[LN_RES_W-1:0];
          end else if (timed_out) begin
            if (slot == '0) shadow_city <= CITY_ERR;
            else            shadow_ln[ln_idx] <= LN_ERR;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        NEXT: begin
          if (slot != SLOT_W'(NUM_CHARS - 1)) slot <= slot + SLOT_W'(1);
        end
        PUBLISH: begin
          char_result1 <= shadow_city;
          char_result2 <= shadow_ln[0];
          char_result3 <= shadow_ln[1];
          char_result4 <= shadow_ln[2];
          char_result5 <= shadow_ln[3];
          char_result6 <= shadow_ln[4];
          char_result7 <= shadow_ln[5];
          char_result8 <= shadow_ln[6];
          result_valid <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
